image_frame_loader: RTL and testbench
=====================================

// Module: image_frame_loader
// PURPOSE
//  Front-end stage for the digit classifier: receives a 32x32 binary pixel stream, assembles
//  it into the 1024-bit image vector, then sequences the TPU controller (enable, reset pulse,
//  wait for done) and latches its digit/overflow result. Sits between the pixel source
//  (drawing pad / UART unpacker) and the TPU controller; owns that controller's ena/iRst_n.
// PARAMETERS
//  IMG_W          32     image width in pixels (IMG_W*IMG_H = 1024 in the shipped design)
//  IMG_H          32     image height in pixels
//  RST_CYCLES     2      cycles tpu_rstn is held low after tpu_ena rises (>=1)
//  TIMEOUT_CYCLES 65535  max cycles waiting for tpu_done before aborting (16-bit counter)
// PORTS
//  clk            in   1     clock
//  iRst_n         in   1     reset, synchronous, active-low
//  pix_valid      in   1     pixel valid
//  pix_sof        in   1     marks pixel 0 of a frame (qualified by pix_valid)
//  pix_data       in   1     pixel value, 1 = ink
//  pix_ready      out  1     loader accepts a pixel this cycle
//  image          out  1024  assembled frame; bit k = pixel k, row-major (k = row*IMG_W+col)
//  tpu_ena        out  1     to TPU controller ena
//  tpu_rstn       out  1     to TPU controller iRst_n
//  tpu_done       in   1     from TPU controller done
//  tpu_num        in   4     from TPU controller num_out
//  tpu_overflow   in   1     from TPU controller overflow
//  result_valid   out  1     result_num/result_ovf valid; held until next frame starts
//  result_num     out  4     classified digit 0-9; 4'hE = timeout, 4'hF = blank frame
//  result_ovf     out  1     overflow reported by TPU for this frame
//  frame_err      out  1     one-cycle pulse: SOF seen mid-frame or data before SOF
//  busy           out  1     high in every state except IDLE
// BEHAVIOUR
//  Reset (iRst_n=0 at clk edge): state=IDLE, pix_ready=1, image=0, tpu_ena=0, tpu_rstn=1,
//   result_valid=0, result_num=0, result_ovf=0, frame_err=0, busy=0, counters=0. Wins over all.
//  Transfer = pix_valid & pix_ready on a rising edge. pix_ready=1 only in IDLE and LOAD.
//  IDLE : transfer with pix_sof=1 -> write bit 0, cnt=1, clear result_valid, go LOAD.
//         transfer with pix_sof=0 -> pixel dropped, frame_err pulse, stay IDLE.
//  LOAD : transfer with pix_sof=0 -> write bit cnt, cnt++. pix_sof=1 -> frame_err pulse,
//         restart: image bit 0 written, bits 1..1023 cleared, cnt=1. Transfer of pixel 1023
//         (cnt==IMG_W*IMG_H-1) -> go START; no gap cycles required between pixels.
//  START: tpu_ena=1, tpu_rstn=0, hold RST_CYCLES cycles -> RUN (tpu_rstn=1, timer=0).
//  RUN  : tpu_ena=1. tpu_done=1 -> latch result_num=tpu_num, result_ovf=tpu_overflow,
//         result_valid=1, tpu_ena=0, go IDLE. Timer reaches TIMEOUT_CYCLES first ->
//         result_num=4'hE, result_ovf=0, result_valid=1, tpu_ena=0, go IDLE.
//  tpu_done sampled only in RUN (stale done from previous frame ignored during START).
//  image is stable from the last-pixel edge until the next accepted SOF; never changes in
//   START/RUN. Latency last pixel -> tpu_rstn high = RST_CYCLES+1 cycles.
//  result_valid drops on the edge accepting the next frame's SOF pixel.
//  Reset mid-frame or mid-RUN: all state discarded, tpu_ena drops the next edge.
// CONFIGURATION
//  BLANK_SKIP_EN defined: a running OR of accepted pixels is kept; if frame completes with
//   all pixels 0, START/RUN are skipped: result_num=4'hF, result_ovf=0, result_valid=1 on
//   the cycle after the last pixel, tpu_ena never asserted.
//  BLANK_SKIP_EN undefined: every complete frame goes to the TPU; 4'hF is never produced.
// TESTING
//  1 Reset then 1024 pixels, pix_sof on 0, pixel k = k[0] -> image = {512{2'b10}}; tpu_ena
//    rises, tpu_rstn low 2 cycles; model done after 50 cycles, num=7 -> result_num=7, valid=1.
//  2 Stream with pix_valid toggling every other cycle -> same image, no pixel lost/duplicated.
//  3 SOF reasserted at pixel 500, then full frame -> one frame_err pulse; image = second frame.
//  4 tpu_done held low, TIMEOUT_CYCLES=100 -> result_num=4'hE after 100 RUN cycles, tpu_ena=0.
//  5 iRst_n low during RUN -> next edge tpu_ena=0, result_valid=0, pix_ready=1, busy=0.
//  6 All-zero frame: with BLANK_SKIP_EN -> result_num=4'hF, tpu_ena never 1; without -> TPU run.

Source files
------------

// File: rtl/image_frame_loader.sv
// Assembles a row-major binary pixel stream into the image vector, then sequences the TPU
// controller and latches its result. Optional build macro: BLANK_SKIP_EN.
module image_frame_loader #(
    parameter int IMG_W          = 32,
    parameter int IMG_H          = 32,
    parameter int RST_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                     clk,
    input  logic                     iRst_n,
    input  logic                     pix_valid,
    input  logic                     pix_sof,
    input  logic                     pix_data,
    output logic                     pix_ready,
    output logic [IMG_W*IMG_H-1:0]   image,
    output logic                     tpu_ena,
    output logic                     tpu_rstn,
    input  logic                     tpu_done,
    input  logic [3:0]               tpu_num,
    input  logic                     tpu_overflow,
    output logic                     result_valid,
    output logic [3:0]               result_num,
    output logic                     result_ovf,
    output logic                     frame_err,
    output logic                     busy
);

    localparam int NPIX  = IMG_W * IMG_H;
    localparam int CNT_W = $clog2(NPIX);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_START = 2'd2;
    localparam logic [1:0] ST_RUN   = 2'd3;

    localparam logic [3:0] NUM_TIMEOUT = 4'hE;
    localparam logic [3:0] NUM_BLANK   = 4'hF;

    logic [1:0]       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [7:0]       rst_cnt_reg;
    logic [15:0]      timer_reg;
    logic             tpu_ena_reg;
    logic             tpu_rstn_reg;
    logic             result_valid_reg;
    logic [3:0]       result_num_reg;
    logic             result_ovf_reg;
    logic             frame_err_reg;
    logic [NPIX-1:0]  image_reg;

    logic xfer;
    logic sof_xfer;
    logic data_xfer;
    logic last_pix;
    logic img_clear;
    logic frame_blank;

    assign pix_ready = (state_reg == ST_IDLE) || (state_reg == ST_LOAD);
    assign xfer      = pix_valid & pix_ready;
    assign sof_xfer  = xfer & pix_sof;
    assign data_xfer = xfer & ~pix_sof & (state_reg == ST_LOAD);
    assign last_pix  = data_xfer && (cnt_reg == CNT_W'(NPIX - 1));
    assign img_clear = sof_xfer && (state_reg == ST_LOAD);

    // Bit 0 is only ever written by an SOF pixel; a mid-frame SOF also wipes the rest.
    genvar gi;
    generate
        for (gi = 0; gi < NPIX; gi++) begin : g_pix
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (!iRst_n)
                        image_reg[gi] <= 1'b0;
                    else if (sof_xfer)
                        image_reg[gi] <= pix_data;
                end
            end else begin : g_rest
                always_ff @(posedge clk) begin
                    if (!iRst_n)
                        image_reg[gi] <= 1'b0;
                    else if (img_clear)
                        image_reg[gi] <= 1'b0;
                    else if (data_xfer && (cnt_reg == CNT_W'(gi)))
                        image_reg[gi] <= pix_data;
                end
            end
        end
    endgenerate

`ifdef BLANK_SKIP_EN
    logic pix_or_reg;

    always_ff @(posedge clk) begin
        if (!iRst_n)
            pix_or_reg <= 1'b0;
        else if (sof_xfer)
            pix_or_reg <= pix_data;
        else if (data_xfer)
            pix_or_reg <= pix_or_reg | pix_data;
    end

    // Includes the last pixel, which is still on the bus when the decision is made.
    assign frame_blank = ~(pix_or_reg | pix_data);
`else
    assign frame_blank = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!iRst_n) begin
            state_reg        <= ST_IDLE;
            cnt_reg          <= '0;
            rst_cnt_reg      <= '0;
            timer_reg        <= '0;
            tpu_ena_reg      <= 1'b0;
            tpu_rstn_reg     <= 1'b1;
            result_valid_reg <= 1'b0;
            result_num_reg   <= 4'h0;
            result_ovf_reg   <= 1'b0;
            frame_err_reg    <= 1'b0;
        end else begin
            frame_err_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (xfer) begin
                        if (pix_sof) begin
                            cnt_reg          <= CNT_W'(1);
                            result_valid_reg <= 1'b0;
                            state_reg        <= ST_LOAD;
                        end else begin
                            frame_err_reg <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (xfer) begin
                        if (pix_sof) begin
                            frame_err_reg <= 1'b1;
                            cnt_reg       <= CNT_W'(1);
                        end else if (last_pix) begin
                            cnt_reg <= '0;
                            if (frame_blank) begin
                                result_num_reg   <= NUM_BLANK;
                                result_ovf_reg   <= 1'b0;
                                result_valid_reg <= 1'b1;
                                state_reg        <= ST_IDLE;
                            end else begin
                                rst_cnt_reg <= '0;
                                state_reg   <= ST_START;
                            end
                        end else begin
                            cnt_reg <= cnt_reg + CNT_W'(1);
                        end
                    end
                end
                ST_START: begin
                    // tpu_ena/tpu_rstn are registered, so rstn is low for exactly RST_CYCLES cycles.
                    if (rst_cnt_reg == 8'(RST_CYCLES)) begin
                        tpu_rstn_reg <= 1'b1;
                        timer_reg    <= '0;
                        state_reg    <= ST_RUN;
                    end else begin
                        tpu_ena_reg  <= 1'b1;
                        tpu_rstn_reg <= 1'b0;
                        rst_cnt_reg  <= rst_cnt_reg + 8'd1;
                    end
                end
                ST_RUN: begin
                    if (tpu_done) begin
                        result_num_reg   <= tpu_num;
                        result_ovf_reg   <= tpu_overflow;
                        result_valid_reg <= 1'b1;
                        tpu_ena_reg      <= 1'b0;
                        state_reg        <= ST_IDLE;
                    end else if (timer_reg == 16'(TIMEOUT_CYCLES - 1)) begin
                        result_num_reg   <= NUM_TIMEOUT;
                        result_ovf_reg   <= 1'b0;
                        result_valid_reg <= 1'b1;
                        tpu_ena_reg      <= 1'b0;
                        state_reg        <= ST_IDLE;
                    end else begin
                        timer_reg <= timer_reg + 16'd1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign image        = image_reg;
    assign tpu_ena      = tpu_ena_reg;
    assign tpu_rstn     = tpu_rstn_reg;
    assign result_valid = result_valid_reg;
    assign result_num   = result_num_reg;
    assign result_ovf   = result_ovf_reg;
    assign frame_err    = frame_err_reg;
    assign busy         = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_image_frame_loader.sv
// Bench for image_frame_loader: pixel driver, behavioural TPU controller model and a
// result scoreboard. Honours BLANK_SKIP_EN for the blank-frame expectation.
module tb_image_frame_loader;

    localparam int NPIX     = 1024;
    localparam int RST_CYC  = 2;
    localparam int TO_CYC   = 100;
    localparam int DONE_LAT = 50;

    logic            clk = 1'b0;
    logic            iRst_n;
    logic            pix_valid, pix_sof, pix_data, pix_ready;
    logic [NPIX-1:0] image;
    logic            tpu_ena, tpu_rstn;
    logic            tpu_done = 1'b0;
    logic [3:0]      tpu_num = 4'h0;
    logic            tpu_overflow = 1'b0;
    logic            result_valid, result_ovf, frame_err, busy;
    logic [3:0]      result_num;

    image_frame_loader #(
        .IMG_W(32), .IMG_H(32), .RST_CYCLES(RST_CYC), .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .clk(clk), .iRst_n(iRst_n),
        .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_data(pix_data), .pix_ready(pix_ready),
        .image(image),
        .tpu_ena(tpu_ena), .tpu_rstn(tpu_rstn), .tpu_done(tpu_done),
        .tpu_num(tpu_num), .tpu_overflow(tpu_overflow),
        .result_valid(result_valid), .result_num(result_num), .result_ovf(result_ovf),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]      num;
        logic            ovf;
        logic [NPIX-1:0] img;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   err_cnt  = 0;
    int   ena_cnt  = 0;
    int   frame_no = 0;
    logic rv_prev  = 1'b0;

    logic [3:0] model_num = 4'h0;
    logic       model_ovf = 1'b0;
    logic       tpu_hang  = 1'b0;
    int         tcnt      = 0;

    task automatic check_val(input string tag, input logic [NPIX-1:0] got, input logic [NPIX-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // TPU controller model: done (with num/ovf captured) DONE_LAT enabled cycles after reset release.
    always @(posedge clk) begin
        if (!tpu_rstn) begin
            tcnt     <= 0;
            tpu_done <= 1'b0;
        end else if (tpu_ena && !tpu_hang) begin
            if (tcnt == DONE_LAT - 1) begin
                tpu_done     <= 1'b1;
                tpu_num      <= model_num;
                tpu_overflow <= model_ovf;
            end
            tcnt <= tcnt + 1;
        end
    end

    always @(negedge clk) begin
        rv_prev <= result_valid;
        if (frame_err) err_cnt <= err_cnt + 1;
        if (tpu_ena)   ena_cnt <= ena_cnt + 1;
        if (result_valid && !rv_prev) begin
            if (sb_q.size() == 0) begin
                check_val("sb_unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                $display("frame %0d: result_num=%0h ovf=%0b (want %0h/%0b)",
                         frame_no, result_num, result_ovf, e.num, e.ovf);
                check_val("result_num", result_num, e.num);
                check_val("result_ovf", result_ovf, e.ovf);
                check_val("image", image, e.img);
            end
            frame_no <= frame_no + 1;
        end
    end

    function automatic logic pat(input int mode, input int k);
        case (mode)
            0:       pat = k[0];
            2:       pat = ((k * 7 + 3) % 5) < 2;
            3:       pat = (k % 3) == 0;
            default: pat = 1'b0;
        endcase
    endfunction

    task automatic send_frame(input int mode, input int gap, input int npix, output logic [NPIX-1:0] img);
        img = '0;
        for (int k = 0; k < npix; k++) begin
            @(negedge clk);
            pix_valid = 1'b1;
            pix_sof   = (k == 0);
            pix_data  = pat(mode, k);
            img[k]    = pix_data;
            @(posedge clk);
            if (gap != 0) begin
                @(negedge clk);
                pix_valid = 1'b0;
                @(posedge clk);
            end
        end
    endtask

    task automatic idle_inputs();
        @(negedge clk);
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        pix_data  = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (busy) check_val("idle_timeout", busy, 0);
    endtask

    task automatic wait_result();
        int n;
        n = 0;
        while (!result_valid && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!result_valid) check_val("result_timeout", result_valid, 1);
        @(negedge clk);
        check_val("sb_drained", sb_q.size(), 0);
    endtask

    task automatic wait_running();
        int n;
        n = 0;
        while (!(tpu_ena && tpu_rstn) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!(tpu_ena && tpu_rstn)) check_val("run_timeout", 0, 1);
    endtask

    initial begin
        logic [NPIX-1:0] img, exp_img;
        exp_t e;
        int   k, low_cnt, cyc, err0, ena0;

        iRst_n = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0; pix_data = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_pix_ready", pix_ready, 1);
        check_val("rst_image", image, 0);
        check_val("rst_tpu_ena", tpu_ena, 0);
        check_val("rst_tpu_rstn", tpu_rstn, 1);
        check_val("rst_result_valid", result_valid, 0);
        check_val("rst_result_num", result_num, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_frame_err", frame_err, 0);
        iRst_n = 1'b1;

        // Data without SOF while idle: dropped with a single frame_err pulse.
        @(negedge clk);
        pix_valid = 1'b1; pix_sof = 1'b0; pix_data = 1'b1;
        @(posedge clk);
        @(negedge clk);
        pix_valid = 1'b0;
        check_val("nosof_err_pulse", frame_err, 1);
        check_val("nosof_stay_idle", busy, 0);
        @(negedge clk);
        check_val("nosof_err_one_cycle", frame_err, 0);

        // Alternating pattern, TPU answers 7 after DONE_LAT cycles; check rstn pulse timing.
        model_num = 4'd7; model_ovf = 1'b0; tpu_hang = 1'b0;
        exp_img = {512{2'b10}};
        e.num = 4'd7; e.ovf = 1'b0; e.img = exp_img;
        sb_q.push_back(e);
        send_frame(0, 0, NPIX, img);
        idle_inputs();
        check_val("t1_ena_after_last", tpu_ena, 0);
        k = 0; low_cnt = 0;
        while (k < 20) begin
            @(negedge clk);
            k++;
            if (!tpu_rstn) low_cnt++;
            else if (low_cnt > 0) break;
        end
        check_val("t1_rstn_low_cycles", low_cnt, RST_CYC);
        check_val("t1_rstn_latency", k, RST_CYC + 1);
        check_val("t1_ena_in_run", tpu_ena, 1);
        wait_result();
        check_val("t1_ena_dropped", tpu_ena, 0);

        // Gapped stream; stale done from the previous run must be ignored.
        wait_idle();
        model_num = 4'd2; model_ovf = 1'b1;
        send_frame(2, 1, NPIX, img);
        e.num = 4'd2; e.ovf = 1'b1; e.img = img;
        sb_q.push_back(e);
        idle_inputs();
        wait_result();

        // SOF restart at pixel 500.
        wait_idle();
        err0 = err_cnt;
        model_num = 4'd5; model_ovf = 1'b0;
        send_frame(3, 0, 500, img);
        exp_img = {512{2'b10}};
        e.num = 4'd5; e.ovf = 1'b0; e.img = exp_img;
        sb_q.push_back(e);
        send_frame(0, 0, NPIX, img);
        idle_inputs();
        wait_result();
        check_val("t3_err_pulses", err_cnt - err0, 1);

        // Timeout after TO_CYC RUN cycles.
        wait_idle();
        tpu_hang = 1'b1;
        send_frame(3, 0, NPIX, img);
        e.num = 4'hE; e.ovf = 1'b0; e.img = img;
        sb_q.push_back(e);
        idle_inputs();
        wait_running();
        cyc = 0;
        while (!result_valid && cyc < 3 * TO_CYC) begin
            @(negedge clk);
            cyc++;
        end
        check_val("t4_timeout_cycles", cyc, TO_CYC);
        check_val("t4_ena_dropped", tpu_ena, 0);
        @(negedge clk);
        check_val("t4_sb_drained", sb_q.size(), 0);

        // Reset during RUN.
        wait_idle();
        send_frame(2, 0, NPIX, img);
        idle_inputs();
        wait_running();
        repeat (5) @(negedge clk);
        iRst_n = 1'b0;
        @(posedge clk);
        #1;
        check_val("t5_ena", tpu_ena, 0);
        check_val("t5_result_valid", result_valid, 0);
        check_val("t5_pix_ready", pix_ready, 1);
        check_val("t5_busy", busy, 0);
        check_val("t5_image", image, 0);
        @(negedge clk);
        iRst_n = 1'b1;
        tpu_hang = 1'b0;

        // All-zero frame.
        wait_idle();
        model_num = 4'd3; model_ovf = 1'b0;
        @(negedge clk);
        ena0 = ena_cnt;
        send_frame(1, 0, NPIX, img);
`ifdef BLANK_SKIP_EN
        e.num = 4'hF;
`else
        e.num = 4'd3;
`endif
        e.ovf = 1'b0; e.img = '0;
        sb_q.push_back(e);
        idle_inputs();
        wait_result();
`ifdef BLANK_SKIP_EN
        check_val("t6_tpu_ena_seen", (ena_cnt - ena0) > 0, 0);
`else
        check_val("t6_tpu_ena_seen", (ena_cnt - ena0) > 0, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
